// File: rtl/mdr_demux_router.sv
// Registered 1-to-N_CH operand demultiplexer with per-channel valid/ready
// holding registers, broadcast, and a sticky out-of-range select flag.
module mdr_demux_router #(
  parameter int DW   = 32,
  parameter int N_CH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 in_data,
  input  logic [((N_CH <= 2) ? 1 : $clog2(N_CH))-1:0] in_sel,
  input  logic                          in_bcast,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [N_CH*DW-1:0]            out_data,
  output logic [N_CH-1:0]               out_valid,
  input  logic [N_CH-1:0]               out_ready,
  output logic                          sel_err,
  input  logic                          sel_err_clr
);

  localparam int SW = (N_CH <= 2) ? 1 : $clog2(N_CH);

  logic [N_CH*DW-1:0] data_q, data_d;
  logic [N_CH-1:0]    valid_q, valid_d;
  logic               sel_err_q, sel_err_d;

  logic [N_CH-1:0]    free;
  logic [N_CH-1:0]    load;
  logic               sel_hit;
  logic               sel_free;
  logic               accept;

  always_comb begin
    free     = ~valid_q | out_ready;
    sel_hit  = 1'b0;
    sel_free = 1'b0;
    load     = '0;
    data_d   = data_q;
    valid_d  = valid_q;
    in_ready = 1'b0;

    for (int k = 0; k < N_CH; k++) begin
      if (in_sel == SW'(k)) begin
        sel_hit  = 1'b1;
        sel_free = free[k];
      end
    end

    // Out-of-range unicast is always accepted so a bad select never stalls the source.
    if (rst)           in_ready = 1'b0;
    else if (in_bcast) in_ready = &free;
    else if (sel_hit)  in_ready = sel_free;
    else               in_ready = 1'b1;

    accept = in_valid & in_ready;

    for (int k = 0; k < N_CH; k++) begin
      load[k] = accept & (in_bcast | (sel_hit & (in_sel == SW'(k))));
      if (load[k]) begin
        data_d[k*DW +: DW] = in_data;
        valid_d[k]         = 1'b1;
      end else if (out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end

    sel_err_d = (accept & ~in_bcast & ~sel_hit) | (sel_err_q & ~sel_err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mdr_demux_router.sv
// Scoreboard bench for mdr_demux_router: a 4-channel instance for routing
// scenarios and a 3-channel instance for out-of-range select handling.
module tb_mdr_demux_router;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-channel, 32-bit instance
  logic [31:0]  a_in_data;
  logic [1:0]   a_in_sel;
  logic         a_in_bcast, a_in_valid, a_in_ready;
  logic [127:0] a_out_data;
  logic [3:0]   a_out_valid, a_out_ready;
  logic         a_sel_err, a_sel_err_clr;

  // 3-channel, 8-bit instance: select value 3 is out of range
  logic [7:0]   b_in_data;
  logic [1:0]   b_in_sel;
  logic         b_in_bcast, b_in_valid, b_in_ready;
  logic [23:0]  b_out_data;
  logic [2:0]   b_out_valid, b_out_ready;
  logic         b_sel_err, b_sel_err_clr;

  mdr_demux_router #(.DW(32), .N_CH(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_bcast(a_in_bcast), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sel_err(a_sel_err), .sel_err_clr(a_sel_err_clr)
  );

  mdr_demux_router #(.DW(8), .N_CH(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_bcast(b_in_bcast), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sel_err(b_sel_err), .sel_err_clr(b_sel_err_clr)
  );

  int total = 0;
  int bad   = 0;

  // Expected words per channel of dut_a, pushed on accept, popped on transfer.
  logic [31:0] sb [4][$];
  logic [31:0] exp_w;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in_data = '0; a_in_sel = '0; a_in_bcast = 0; a_in_valid = 0;
    a_out_ready = '0; a_sel_err_clr = 0;
    b_in_data = '0; b_in_sel = '0; b_in_bcast = 0; b_in_valid = 0;
    b_out_ready = '0; b_sel_err_clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    a_in_valid = 1;
    #1;
    total++;
    if (a_in_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_in_ready: got %b expected 0", a_in_ready);
    end
    tick(); tick();
    a_in_valid = 0;
    total++;
    if (a_out_valid !== 4'b0000 || a_out_data !== 128'd0 || a_sel_err !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_state: valid=%b data=%h err=%b expected 0/0/0",
                      a_out_valid, a_out_data, a_sel_err);
    end
    total++;
    if (b_out_valid !== 3'b000 || b_sel_err !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_state_b: valid=%b err=%b expected 0/0", b_out_valid, b_sel_err);
    end
    rst = 0;
    #1;
  endtask

  task automatic test_unicast();
    a_in_sel = 2; a_in_data = 32'hA5A5_0001; a_in_valid = 1;
    #1;
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL unicast_in_ready: got %b expected 1", a_in_ready);
    end
    sb[2].push_back(a_in_data);
    tick();
    a_in_valid = 0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (a_out_valid !== 4'b0100 || a_out_data[64 +: 32] !== sb[2][0]) begin
        bad++; $display("[TB] FAIL unicast_hold cyc%0d: valid=%b data=%h expected 0100/%h",
                        c, a_out_valid, a_out_data[64 +: 32], sb[2][0]);
      end
      tick();
    end
    a_out_ready[2] = 1;
    exp_w = sb[2].pop_front();
    #1;
    total++;
    if (a_out_data[64 +: 32] !== exp_w) begin
      bad++; $display("[TB] FAIL unicast_xfer: got %h expected %h", a_out_data[64 +: 32], exp_w);
    end
    tick();
    a_out_ready = '0;
    total++;
    if (a_out_valid !== 4'b0000) begin
      bad++; $display("[TB] FAIL unicast_drain: valid=%b expected 0000", a_out_valid);
    end
  endtask

  task automatic test_backpressure();
    a_in_sel = 1; a_in_data = 32'h22; a_in_valid = 1;
    sb[1].push_back(32'h22);
    tick();
    a_in_data = 32'h11;
    #1;
    total++;
    if (a_in_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_in_ready_stall: got %b expected 0", a_in_ready);
    end
    tick();
    total++;
    if (a_out_valid[1] !== 1'b1 || a_out_data[32 +: 32] !== sb[1][0]) begin
      bad++; $display("[TB] FAIL bp_held: valid=%b data=%h expected 1/%h",
                      a_out_valid[1], a_out_data[32 +: 32], sb[1][0]);
    end
    a_out_ready[1] = 1;
    #1;
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL bp_in_ready_release: got %b expected 1", a_in_ready);
    end
    exp_w = sb[1].pop_front();
    total++;
    if (a_out_data[32 +: 32] !== exp_w) begin
      bad++; $display("[TB] FAIL bp_xfer_old: got %h expected %h", a_out_data[32 +: 32], exp_w);
    end
    sb[1].push_back(32'h11);
    tick();
    a_in_valid = 0; a_out_ready = '0;
    total++;
    if (a_out_valid[1] !== 1'b1 || a_out_data[32 +: 32] !== sb[1][0]) begin
      bad++; $display("[TB] FAIL bp_no_bubble: valid=%b data=%h expected 1/%h",
                      a_out_valid[1], a_out_data[32 +: 32], sb[1][0]);
    end
    a_out_ready[1] = 1;
    exp_w = sb[1].pop_front();
    tick();
    a_out_ready = '0;
    total++;
    if (a_out_valid !== 4'b0000) begin
      bad++; $display("[TB] FAIL bp_drain: valid=%b expected 0000", a_out_valid);
    end
  endtask

  task automatic test_streaming();
    a_out_ready[0] = 1;
    for (int i = 1; i <= 4; i++) begin
      a_in_sel = 0; a_in_data = i; a_in_valid = 1;
      #1;
      total++;
      if (a_in_ready !== 1'b1) begin
        bad++; $display("[TB] FAIL stream_in_ready word%0d: got %b expected 1", i, a_in_ready);
      end
      if (i > 1) begin
        exp_w = sb[0].pop_front();
        total++;
        if (a_out_valid[0] !== 1'b1 || a_out_data[0 +: 32] !== exp_w) begin
          bad++; $display("[TB] FAIL stream_out word%0d: valid=%b data=%h expected 1/%h",
                          i - 1, a_out_valid[0], a_out_data[0 +: 32], exp_w);
        end
      end
      sb[0].push_back(i);
      tick();
    end
    a_in_valid = 0;
    exp_w = sb[0].pop_front();
    #1;
    total++;
    if (a_out_valid[0] !== 1'b1 || a_out_data[0 +: 32] !== exp_w) begin
      bad++; $display("[TB] FAIL stream_out word4: valid=%b data=%h expected 1/%h",
                      a_out_valid[0], a_out_data[0 +: 32], exp_w);
    end
    tick();
    a_out_ready = '0;
    total++;
    if (a_out_valid !== 4'b0000) begin
      bad++; $display("[TB] FAIL stream_drain: valid=%b expected 0000", a_out_valid);
    end
  endtask

  task automatic test_broadcast();
    a_in_sel = 3; a_in_data = 32'h33; a_in_valid = 1;
    sb[3].push_back(32'h33);
    tick();
    a_in_bcast = 1; a_in_sel = 0; a_in_data = 32'hBEEF;
    #1;
    total++;
    if (a_in_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL bcast_in_ready_stall: got %b expected 0", a_in_ready);
    end
    tick();
    total++;
    if (a_out_valid !== 4'b1000 || a_out_data[96 +: 32] !== sb[3][0]) begin
      bad++; $display("[TB] FAIL bcast_no_partial: valid=%b data3=%h expected 1000/%h",
                      a_out_valid, a_out_data[96 +: 32], sb[3][0]);
    end
    a_out_ready[3] = 1;
    #1;
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL bcast_in_ready_release: got %b expected 1", a_in_ready);
    end
    exp_w = sb[3].pop_front();
    for (int k = 0; k < 4; k++) sb[k].push_back(32'hBEEF);
    tick();
    a_in_valid = 0; a_in_bcast = 0; a_out_ready = '0;
    total++;
    if (a_out_valid !== 4'b1111 || a_sel_err !== 1'b0) begin
      bad++; $display("[TB] FAIL bcast_valid: valid=%b err=%b expected 1111/0", a_out_valid, a_sel_err);
    end
    a_out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_w = sb[k].pop_front();
      total++;
      if (a_out_data[k*32 +: 32] !== exp_w) begin
        bad++; $display("[TB] FAIL bcast_data ch%0d: got %h expected %h", k, a_out_data[k*32 +: 32], exp_w);
      end
    end
    tick();
    a_out_ready = '0;
    total++;
    if (a_out_valid !== 4'b0000) begin
      bad++; $display("[TB] FAIL bcast_drain: valid=%b expected 0000", a_out_valid);
    end
  endtask

  task automatic test_sel_err();
    b_in_sel = 3; b_in_data = 8'h5A; b_in_valid = 1;
    #1;
    total++;
    if (b_in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL selerr_in_ready: got %b expected 1", b_in_ready);
    end
    tick();
    b_in_valid = 0;
    total++;
    if (b_out_valid !== 3'b000 || b_sel_err !== 1'b1) begin
      bad++; $display("[TB] FAIL selerr_set: valid=%b err=%b expected 000/1", b_out_valid, b_sel_err);
    end
    tick();
    total++;
    if (b_sel_err !== 1'b1) begin
      bad++; $display("[TB] FAIL selerr_sticky: got %b expected 1", b_sel_err);
    end
    b_in_valid = 1; b_sel_err_clr = 1;
    tick();
    b_in_valid = 0;
    total++;
    if (b_sel_err !== 1'b1) begin
      bad++; $display("[TB] FAIL selerr_set_beats_clr: got %b expected 1", b_sel_err);
    end
    tick();
    b_sel_err_clr = 0;
    total++;
    if (b_sel_err !== 1'b0) begin
      bad++; $display("[TB] FAIL selerr_clr: got %b expected 0", b_sel_err);
    end
    b_in_bcast = 1; b_in_sel = 3; b_in_data = 8'hC3; b_in_valid = 1;
    tick();
    b_in_valid = 0; b_in_bcast = 0;
    total++;
    if (b_out_valid !== 3'b111 || b_out_data !== 24'hC3C3C3 || b_sel_err !== 1'b0) begin
      bad++; $display("[TB] FAIL selerr_bcast: valid=%b data=%h err=%b expected 111/c3c3c3/0",
                      b_out_valid, b_out_data, b_sel_err);
    end
    b_out_ready = 3'b111;
    tick();
    b_out_ready = '0;
    total++;
    if (b_out_valid !== 3'b000 || b_out_data !== 24'hC3C3C3) begin
      bad++; $display("[TB] FAIL selerr_bcast_drain: valid=%b data=%h expected 000/c3c3c3",
                      b_out_valid, b_out_data);
    end
  endtask

  task automatic test_reset_mid();
    a_in_sel = 0; a_in_data = 32'h100; a_in_valid = 1;
    tick();
    a_in_sel = 2; a_in_data = 32'h102;
    tick();
    a_in_valid = 0;
    b_in_sel = 3; b_in_valid = 1;
    tick();
    b_in_valid = 0;
    total++;
    if (a_out_valid !== 4'b0101 || b_sel_err !== 1'b1) begin
      bad++; $display("[TB] FAIL rstmid_setup: valid=%b err=%b expected 0101/1", a_out_valid, b_sel_err);
    end
    rst = 1; a_in_sel = 1; a_in_data = 32'h777; a_in_valid = 1;
    #1;
    total++;
    if (a_in_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL rstmid_in_ready: got %b expected 0", a_in_ready);
    end
    tick();
    rst = 0; a_in_valid = 0;
    total++;
    if (a_out_valid !== 4'b0000 || a_out_data !== 128'd0 || b_sel_err !== 1'b0) begin
      bad++; $display("[TB] FAIL rstmid_state: valid=%b data=%h err=%b expected 0/0/0",
                      a_out_valid, a_out_data, b_sel_err);
    end
    tick();
    total++;
    if (a_out_valid !== 4'b0000) begin
      bad++; $display("[TB] FAIL rstmid_no_leak: valid=%b expected 0000", a_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_streaming();
    test_broadcast();
    test_sel_err();
    test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (sb[k].size() !== 0) begin
        bad++; $display("[TB] FAIL sb_empty ch%0d: got %0d entries expected 0", k, sb[k].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdr_demux_router.md
Name: mdr_demux_router

Overview:
- Parametrised, registered 1-to-N_CH demultiplexer for routing operand words to the MDR datapath units.
- Successor to the combinational 1-to-4 operand demux. Adds:
  - a valid/ready handshake on the input and on every output;
  - a one-entry holding register per output channel;
  - broadcast mode;
  - detection of out-of-range selects.
- Sits between the operand source and the N_CH consumer units. Each consumer may stall independently.

Parameters:
- DW, 32, data word width in bits (≥1).
- N_CH, 4, number of output channels (2..16).
- SW, derived localparam = max(1, $clog2(N_CH)), select width. Not user-overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  DW  input word.
- in_sel  in  SW  destination channel index.
- in_bcast  in  1  when 1, in_sel is ignored and the word goes to all channels.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the input this cycle.
- out_data  out  N_CH*DW  channel k occupies bits [k*DW +: DW].
- out_valid  out  N_CH  channel k holds a word.
- out_ready  in  N_CH  consumer k takes the word this cycle.
- sel_err  out  1  sticky flag: a unicast word with in_sel ≥ N_CH was received.
- sel_err_clr  in  1  clears sel_err.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid = 0 for all channels; out_data = 0; sel_err = 0.
  - in_ready is forced to 0 while rst=1.
  - Any in-flight word is discarded; no partial transfer survives.
- Per-channel handshake:
  - Channel k transfers when out_valid[k] & out_ready[k].
  - The channel is "free" when ~out_valid[k] | out_ready[k] (empty, or draining this cycle).
  - Once out_valid[k]=1, out_data[k] is held stable until that transfer occurs.
- in_ready is combinational from in_sel, in_bcast, out_valid and out_ready. It never depends on in_valid.
  - Unicast, in_sel < N_CH: in_ready = free[in_sel].
  - Broadcast: in_ready = AND of free[k] over all k. There is no partial broadcast.
  - Unicast, in_sel ≥ N_CH: in_ready = 1, so the word is dropped and never stalls the source.
- Accept is in_valid & in_ready. On accept:
  - Unicast, valid sel: the next cycle has out_data[sel] = in_data and out_valid[sel] = 1.
  - Broadcast: every channel loads in_data and sets out_valid.
  - Invalid sel: no channel changes; sel_err = 1 next cycle.
- Latency is exactly 1 cycle from accept to out_valid. Throughput is 1 word per cycle per channel when the consumer holds ready=1.
- Simultaneous drain and load on the same channel: the load wins. out_valid stays 1 and out_data takes the new word. No bubble.
- A channel that is not loaded and is transferring clears out_valid next cycle. Otherwise it holds.
- sel_err:
  - Set has priority over sel_err_clr in the same cycle.
  - sel_err_clr alone clears it next cycle.
  - Broadcast never sets sel_err, whatever the value of in_sel.
- out_data of an invalid channel retains its last value. It is not zeroed after a drain.
- Consumers may raise out_ready with no word present. This has no effect.
- Reset asserted mid-transfer: all held words are lost and outputs return to reset values the next cycle.

Test Plan:
- Reset, then unicast: rst for 2 cycles, then in_sel=2, in_data=0xA5A5_0001, in_valid=1 for 1 cycle, all out_ready=0.
  - Required: out_valid=4'b0100 and out_data[2]=0xA5A5_0001 on the next cycle, held over 5 cycles.
  - Then raise out_ready[2]: out_valid=0 one cycle later.
- Backpressure: channel 1 full with out_ready[1]=0, present in_sel=1, data 0x11.
  - Required: in_ready=0 and the word held.
  - Raise out_ready[1] in the same cycle: in_ready=1, and next cycle out_data[1]=0x11 with out_valid[1] still 1 (no bubble).
- Streaming: in_sel=0 with words 1,2,3,4 on consecutive cycles and out_ready[0]=1.
  - Required: out_data[0] shows 1,2,3,4 on consecutive cycles, each 1 cycle after accept; in_ready stays 1 throughout.
- Broadcast: channel 3 full and stalled; present in_bcast=1, data 0xBEEF.
  - Required: in_ready=0 and no channel loads.
  - Release out_ready[3]: all four channels show 0xBEEF with out_valid=4'b1111 the next cycle.
- Out-of-range select: parametrise N_CH=3 (SW=2), send in_sel=3.
  - Required: in_ready=1, no out_valid changes, sel_err=1 next cycle and sticky.
  - Assert sel_err_clr together with another in_sel=3 word: sel_err stays 1. Clear alone: sel_err=0.
- Reset mid-operation: channels 0 and 2 full, assert rst for 1 cycle.
  - Required: out_valid=0 and sel_err=0 next cycle; in_ready=0 during rst.
